// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch sequencer: state encoding, PC width
// and default geometry of the instruction memory and output buffer.
package fetch_pkg;

  localparam int PC_W          = 32;
  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;
  localparam int BUF_DEPTH_DEF = 2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Word-address increment; wraps 0xFFFFFFFF -> 0 by width.
  function automatic logic [PC_W-1:0] pc_incr(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, instr} entries between instruction memory and decode.
// Flush wins over push; push and pop in the same cycle are allowed when full.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF,
  localparam int ENT_W = PC_W + DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [ENT_W-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [ENT_W-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues reads to a 1-cycle instruction
// memory and hands {pc, instr} to decode. Optional counters under FETCH_PERF_CNT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_addr,
  input  logic              halt_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic              halted,
  output logic [0:0]        dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       fetch_cnt
`endif
);

  // Decode handshake: a transfer happens on a rising edge where out_valid and
  // out_ready are both high; out_pc/out_instr are held stable while out_valid is
  // high and out_ready is low, and out_valid never depends on out_ready.

  localparam int ENT_W = PC_W + DATA_W;
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(BUF_DEPTH);

  logic [0:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             epoch_q, epoch_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_epoch_q, inflight_epoch_d;
  logic [ENT_W-1:0] last_q, last_d;

  logic [ENT_W-1:0] head;
  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occ_sum;

  fetch_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({inflight_pc_q, mem_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (buf_count)
  );

  assign pop  = ~buf_empty & out_ready;
  assign push = inflight_q & (inflight_epoch_q == epoch_q) & (~buf_full | pop);

  // A slot freed by this cycle's pop is counted as free, so streaming runs at
  // one word per cycle with only BUF_DEPTH entries.
  assign occ_sum = {1'b0, buf_count}
                 + {{CNT_W{1'b0}}, inflight_q}
                 - {{CNT_W{1'b0}}, pop};

  assign issue = ~rst & (state_q == ST_RUN) & ~redirect_valid & (occ_sum < OCC_LIMIT);

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue;
    inflight_pc_d    = issue ? pc_q : inflight_pc_q;
    inflight_epoch_d = epoch_q;
    last_d           = pop ? head : last_q;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = redirect_addr;
      epoch_d = ~epoch_q;
    end else begin
      if ((state_q == ST_RUN) && halt_req) begin
        state_d = ST_HALT;
      end
      if (issue) begin
        pc_d = pc_incr(pc_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_RUN;
      pc_q             <= '0;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      last_q           <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      last_q           <= last_d;
    end
  end

  // With an empty buffer the output shows the last word handed to decode.
  assign out_valid = ~buf_empty;
  assign out_pc    = buf_empty ? last_q[ENT_W-1:DATA_W] : head[ENT_W-1:DATA_W];
  assign out_instr = buf_empty ? last_q[DATA_W-1:0]     : head[DATA_W-1:0];
  assign mem_rd_en = issue;
  assign mem_addr  = pc_q[ADDR_W-1:0];
  assign halted    = (state_q == ST_HALT);
  assign dbg_state = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if ((state_q == ST_RUN) && ~issue && ~redirect_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pop && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fetch_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model, scoreboard of expected
// {pc, instr} transfers, directed phases for stall, redirect, halt, wrap and reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        halt_req;
  logic        mem_rd_en;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        halted;
  logic [0:0]  dbg_state;

  logic [31:0] mem [128];
  logic [63:0] exp_q[$];
  logic [31:0] exp_next_pc;
  int          checks;
  int          errors;
  int          xfer_cnt;
  int          mark;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory model: data one cycle after the read strobe
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h100 + i;
    mem_data = '0;
  end
  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({exp_next_pc, 32'h100 + {25'b0, exp_next_pc[6:0]}});
      exp_next_pc = exp_next_pc + 32'd1;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start, input int n);
    exp_q.delete();
    exp_next_pc = start;
    push_exp(n);
  endtask

  // scoreboard: every transfer pops and compares the oldest expected entry
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("xfer_exp_avail", 64'(exp_q.size()), 64'd1);
      end else begin
        check("xfer", {out_pc, out_instr}, exp_q.pop_front());
      end
      xfer_cnt++;
    end
  end

  initial begin
    checks = 0; errors = 0; xfer_cnt = 0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = '0;
    halt_req = 1'b0; out_ready = 1'b1; exp_next_pc = '0;

    // reset state
    repeat (3) step();
    sample();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_out", {out_pc, out_instr}, 64'd0);

    // test 1: latency and streaming
    step();
    rst = 1'b0;
    restart_stream(32'd0, 40);
    sample();
    check("c0_rd_en", 64'(mem_rd_en), 64'd1);
    check("c0_out_valid", 64'(out_valid), 64'd0);
    step(); sample();
    check("c1_out_valid", 64'(out_valid), 64'd0);
    check("c1_addr", 64'(mem_addr), 64'd1);
    step(); sample();
    check("c2_out_valid", 64'(out_valid), 64'd1);
    check("c2_out_pc", 64'(out_pc), 64'd0);
    step();
    mark = xfer_cnt;
    repeat (10) step();
    check("throughput", 64'(xfer_cnt - mark), 64'd10);

    // test 2: backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("stall_rd_en", 64'(mem_rd_en), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_head", {out_pc, out_instr}, exp_q[0]);
      step();
    end
    out_ready = 1'b1;
    mark = xfer_cnt;
    repeat (10) step();
    check("release_xfers", 64'(xfer_cnt - mark), 64'd10);

    // test 3: redirect while streaming
    redirect_valid = 1'b1;
    redirect_addr  = 32'h40;
    sample();
    check("redir_no_issue", 64'(mem_rd_en), 64'd0);
    step();
    redirect_valid = 1'b0;
    restart_stream(32'h40, 20);
    sample();
    check("redir_valid_r1", 64'(out_valid), 64'd0);
    check("redir_addr_r1", {63'd0, mem_rd_en} << 8 | 64'(mem_addr), (64'd1 << 8) | 64'h40);
    step(); sample();
    check("redir_valid_r2", 64'(out_valid), 64'd0);
    step(); sample();
    check("redir_pc_r3", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h40});
    repeat (6) step();

    // test 4: halt drains, then redirect together with halt_req resumes
    halt_req = 1'b1;
    mark = xfer_cnt;
    repeat (6) step();
    check("halt_drain", 64'(xfer_cnt - mark), 64'd3);
    sample();
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_state", 64'(dbg_state), 64'd1);
    check("halt_out_valid", 64'(out_valid), 64'd0);
    check("halt_rd_en", 64'(mem_rd_en), 64'd0);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h10;
    restart_stream(32'h10, 20);
    sample();
    check("halt_redir_no_issue", 64'(mem_rd_en), 64'd0);
    step();
    redirect_valid = 1'b0;
    halt_req = 1'b0;
    sample();
    check("resume_halted", 64'(halted), 64'd0);
    check("resume_addr", {63'd0, mem_rd_en} << 8 | 64'(mem_addr), (64'd1 << 8) | 64'h10);
    repeat (6) step();

    // test 5: PC wrap
    redirect_valid = 1'b1;
    redirect_addr  = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    restart_stream(32'hFFFF_FFFF, 8);
    sample();
    check("wrap_addr_hi", {63'd0, mem_rd_en} << 8 | 64'(mem_addr), (64'd1 << 8) | 64'h7F);
    step(); sample();
    check("wrap_addr_lo", {63'd0, mem_rd_en} << 8 | 64'(mem_addr), (64'd1 << 8) | 64'h00);
    step(); sample();
    check("wrap_head", {out_pc, out_instr}, {32'hFFFF_FFFF, 32'h17F});
    repeat (5) step();

    // test 6: reset with a full buffer
    out_ready = 1'b0;
    repeat (3) step();
    sample();
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_rd_en", 64'(mem_rd_en), 64'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    restart_stream(32'd0, 10);
    sample();
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_addr", {63'd0, mem_rd_en} << 8 | 64'(mem_addr), 64'd1 << 8);
    step(); sample();
    check("mrst_c1_valid", 64'(out_valid), 64'd0);
    step(); sample();
    check("mrst_c2_head", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'd0});
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
